// File: rtl/fpu_issue_queue_if.sv
// Core-to-FPU issue bundle: instruction handshake in, FIFO head out, plus flush and occupancy.
// Latency/backpressure live in the queue; this only groups the signals.
// master = core/FPU environment side, slave = the issue queue.
interface fpu_issue_queue_if #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_instr;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic                  issue_accept;
  logic                  fpu_full;
  logic                  fpu_enable;
  logic [31:0]           fpu_instruction;
  logic [X_ID_WIDTH-1:0] fpu_id;
  logic [CNT_W-1:0]      count;

  modport master (
    output flush, issue_valid, issue_instr, issue_id, fpu_full,
    input  issue_ready, issue_accept, fpu_enable, fpu_instruction, fpu_id, count
  );

  modport slave (
    input  flush, issue_valid, issue_instr, issue_id, fpu_full,
    output issue_ready, issue_accept, fpu_enable, fpu_instruction, fpu_id, count
  );
endinterface

// File: rtl/fpu_issue_queue.sv
// DEPTH-entry FIFO of decoded single-precision FP instructions feeding the FPU.
// Latency: push at edge N, earliest delivery at edge N+1 (no bypass).
// Backpressure: issue_ready drops when full or flushing; fpu_full freezes the head.
module fpu_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4
) (
  input  logic             ck,
  input  logic             rst,
  fpu_issue_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]           instrMem [DEPTH];
  logic [X_ID_WIDTH-1:0] idMem    [DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [CNT_W-1:0]      occ;

  logic [6:0] opc;
  logic [2:0] funct3;
  logic [1:0] fmt;
  logic       legalOp;
  logic       dupId;
  logic       headVld;
  logic       doPush;
  logic       doPop;

  assign opc    = q.issue_instr[6:0];
  assign funct3 = q.issue_instr[14:12];
  assign fmt    = q.issue_instr[26:25];

  // Loads/stores qualify on width (funct3), arithmetic on the fmt field (single precision).
  always_comb begin
    legalOp = 1'b0;
    case (opc)
      7'b0000111, 7'b0100111:
        legalOp = (funct3 == 3'b010);
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111, 7'b1010011:
        legalOp = (fmt == 2'b00);
      default:
        legalOp = 1'b0;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the occupancy;
  // an entry popping this cycle is still live here.
  always_comb begin
    dupId = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(PTR_W'(PTR_W'(k) - rdPtr)) < occ) && (idMem[k] == q.issue_id))
        dupId = 1'b1;
    end
  end

  assign headVld           = (occ != '0);
  assign q.issue_ready     = rst && !q.flush && (occ < CNT_W'(DEPTH));
  assign q.issue_accept    = legalOp && !dupId;
  assign q.fpu_enable      = headVld && !q.fpu_full && !q.flush;
  assign q.fpu_instruction = headVld ? instrMem[rdPtr] : '0;
  assign q.fpu_id          = headVld ? idMem[rdPtr] : '0;
  assign q.count           = occ;

  assign doPush = q.issue_valid && q.issue_ready && q.issue_accept;
  assign doPop  = q.fpu_enable;

  always_ff @(posedge ck) begin
    if (!rst || q.flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (doPush)
        wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)
        rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge ck) begin
    if (doPush) begin
      instrMem[wrPtr] <= q.issue_instr;
      idMem[wrPtr]    <= q.issue_id;
    end
  end
endmodule
